dac_sample_sequencer: RTL and testbench



---
 rtl/dac_seq_pkg.sv | 29 ++
 rtl/sample_fifo.sv | 75 +++++++
 rtl/dac_sample_sequencer.sv | 162 ++++++++++++++++
 tb/tb_dac_sample_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC sample sequencer.
//   BYTE_W            host byte width
//   DEF_BW/DEPTH/DIV_W default sample width, FIFO depth, rate divider width
//   sched_state_t     playback scheduler states
//   asm_state_t       byte assembler states
//   level_w()         width of a FIFO occupancy count for a given depth
package dac_seq_pkg;

   localparam int BYTE_W    = 8;
   localparam int DEF_BW    = 16;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_DIV_W = 16;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } sched_state_t;

   typedef enum logic {
      A_LO = 1'b0,
      A_HI = 1'b1
   } asm_state_t;

   // Occupancy runs 0..DEPTH inclusive, so one bit more than the pointer.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO, DEPTH entries of BW bits (DEPTH a power of 2).
//   clk, rst_n   clock, async active-low reset
//   push, din    write din when not full
//   pop          advance head when not empty
//   flush        synchronous empty; wins over push/pop
//   head         entry at the read pointer (valid when !empty)
//   full, empty  status from the registered level
//   level        current occupancy
// A push into an empty FIFO is not visible at head until the next cycle.
module sample_fifo
   import dac_seq_pkg::*;
#(
   parameter int BW    = DEF_BW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [BW-1:0]          din,
   output logic [BW-1:0]          head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);

   logic [BW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign head    = mem[rd_ptr];

   // Storage needs no reset: only entries below level are ever read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Feeds the delta-sigma modulator with samples at a programmable rate.
// Host bytes (low then high) are assembled into signed BW-bit samples,
// buffered in a FIFO, and released one per rate tick to dac_o.
//   clk, rst_n      clock, async active-low reset
//   ena             tile enable; low freezes the block
//   clear_i         synchronous flush, wins over every same-cycle event
//   byte_i/byte_valid_i/byte_ready_o   host byte handshake
//   rate_div_i      playback period minus 1, in clk cycles
//   dac_o           registered sample to the modulator
//   dac_strobe_o    one-cycle pulse when dac_o updates
//   underflow_o     sticky, cleared only by clear_i or reset
//   fifo_level_o    FIFO occupancy
//   playing_o       scheduler in RUN
//
// Scheduler states:
//   state  | meaning
//   S_IDLE | priming: counter held at 0, no pops, wait for level >= PRIME
//   S_RUN  | playback: counter counts up, tick at counter >= rate_div_i
module dac_sample_sequencer
   import dac_seq_pkg::*;
#(
   parameter int BW    = DEF_BW,
   parameter int DEPTH = DEF_DEPTH,
   parameter int DIV_W = DEF_DIV_W,
   parameter int PRIME = DEPTH / 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   clear_i,
   input  logic [BYTE_W-1:0]      byte_i,
   input  logic                   byte_valid_i,
   output logic                   byte_ready_o,
   input  logic [DIV_W-1:0]       rate_div_i,
   output logic [BW-1:0]          dac_o,
   output logic                   dac_strobe_o,
   output logic                   underflow_o,
   output logic [$clog2(DEPTH):0] fifo_level_o,
   output logic                   playing_o
);

   localparam int              LW        = level_w(DEPTH);
   localparam logic [LW-1:0]   PRIME_LVL = LW'(PRIME);

   sched_state_t      state_q;
   sched_state_t      state_nxt;
   asm_state_t        asm_q;
   logic [DIV_W-1:0]  cnt_q;
   logic [DIV_W-1:0]  cnt_nxt;
   logic [BYTE_W-1:0] low_q;
   logic              tick;
   logic              byte_fire;
   logic              push;
   logic              pop;
   logic [BW-1:0]     fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LW-1:0]     fifo_level;

   assign byte_ready_o = ena & ~fifo_full & ~clear_i;
   assign byte_fire    = byte_valid_i & byte_ready_o;
   assign push         = byte_fire & (asm_q == A_HI);
   // tick is already gated by ena and clear_i in the scheduler.
   assign pop          = tick & ~fifo_empty;

   assign fifo_level_o = fifo_level;
   assign playing_o    = (state_q == S_RUN);

   sample_fifo #(
      .BW    (BW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (clear_i),
      .din   ({byte_i, low_q}),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // The >= compare means a rate lowered below the running count ticks at
   // once instead of waiting for the counter to wrap.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      tick      = 1'b0;
      if (clear_i) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
      end else if (ena) begin
         case (state_q)
            S_IDLE: begin
               cnt_nxt = '0;
               if (fifo_level >= PRIME_LVL) begin
                  state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               if (cnt_q >= rate_div_i) begin
                  tick    = 1'b1;
                  cnt_nxt = '0;
                  if (fifo_empty) begin
                     state_nxt = S_IDLE;
                  end
               end else begin
                  cnt_nxt = cnt_q + 1'b1;
               end
            end
            default: begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q        <= A_LO;
         low_q        <= '0;
         dac_o        <= '0;
         dac_strobe_o <= 1'b0;
         underflow_o  <= 1'b0;
      end else if (clear_i) begin
         asm_q        <= A_LO;
         dac_o        <= '0;
         dac_strobe_o <= 1'b0;
         underflow_o  <= 1'b0;
      end else begin
         if (byte_fire) begin
            if (asm_q == A_LO) begin
               low_q <= byte_i;
               asm_q <= A_HI;
            end else begin
               asm_q <= A_LO;
            end
         end
         if (pop) begin
            dac_o <= fifo_head;
         end
         dac_strobe_o <= pop;
         if (tick && fifo_empty) begin
            underflow_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
module tb_dac_sample_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        clear_i;
   logic [7:0]  byte_i;
   logic        byte_valid_i;
   logic        byte_ready_o;
   logic [15:0] rate_div_i;
   logic [15:0] dac_o;
   logic        dac_strobe_o;
   logic        underflow_o;
   logic [2:0]  fifo_level_o;
   logic        playing_o;

   int tests_run    = 0;
   int tests_failed = 0;

   dac_sample_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .clear_i      (clear_i),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .rate_div_i   (rate_div_i),
      .dac_o        (dac_o),
      .dac_strobe_o (dac_strobe_o),
      .underflow_o  (underflow_o),
      .fifo_level_o (fifo_level_o),
      .playing_o    (playing_o)
   );

   always #5 clk = ~clk;

   // Reference model: a sample queue, a pending low byte, a period counter
   // and a playing flag, updated once per clock from the rules of operation.
   logic [15:0] m_q [$];
   bit          m_have_lo;
   logic [7:0]  m_lo;
   int unsigned m_cnt;
   bit          m_run;
   logic [15:0] m_dac;
   bit          m_strobe;
   bit          m_uf;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_have_lo = 0;
      m_lo      = '0;
      m_cnt     = 0;
      m_run     = 0;
      m_dac     = '0;
      m_strobe  = 0;
      m_uf      = 0;
   endfunction

   function automatic bit model_ready();
      return ena && (m_q.size() < 4) && !clear_i;
   endfunction

   function automatic void model_update();
      int  lvl;
      bit  fire;
      lvl = m_q.size();
      fire = byte_valid_i && model_ready();
      m_strobe = 0;
      if (clear_i) begin
         m_q.delete();
         m_have_lo = 0;
         m_cnt     = 0;
         m_run     = 0;
         m_uf      = 0;
         m_dac     = '0;
      end else if (ena) begin
         if (m_run) begin
            if (m_cnt >= rate_div_i) begin
               m_cnt = 0;
               if (lvl > 0) begin
                  m_dac    = m_q.pop_front();
                  m_strobe = 1;
               end else begin
                  m_uf  = 1;
                  m_run = 0;
               end
            end else begin
               m_cnt++;
            end
         end else if (lvl >= 2) begin
            m_run = 1;
         end
         if (fire) begin
            if (m_have_lo) begin
               m_q.push_back({byte_i, m_lo});
               m_have_lo = 0;
            end else begin
               m_lo      = byte_i;
               m_have_lo = 1;
            end
         end
      end
   endfunction

   task automatic check_outputs();
      check_val("dac", dac_o, m_dac);
      check_val("strobe", dac_strobe_o, m_strobe);
      check_val("underflow", underflow_o, m_uf);
      check_val("level", fifo_level_o, m_q.size());
      check_val("playing", playing_o, m_run);
   endtask

   // Inputs are set by the caller at posedge+1; ready is checked before the
   // edge, registered outputs one time unit after it.
   task automatic step();
      #1;
      check_val("ready", byte_ready_o, model_ready());
      @(posedge clk);
      model_update();
      #1;
      check_outputs();
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_valid_i = 1'b1;
      byte_i       = b;
      step();
      byte_valid_i = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
   endtask

   int          n;
   logic [15:0] seen [$];

   initial begin
      rst_n = 1'b0; ena = 1'b0; clear_i = 1'b0; byte_i = '0;
      byte_valid_i = 1'b0; rate_div_i = 16'd3;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ready", byte_ready_o, ena);
      rst_n = 1'b1;
      check_outputs();

      // Playback at period 4 and underflow.
      ena = 1'b1;
      send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
      check_val("t2_level", fifo_level_o, 2);
      n = 0;
      while (!playing_o && n < 10) begin step(); n++; end
      check_val("t2_run", playing_o, 1);
      n = 0;
      do begin step(); n++; end while (!dac_strobe_o && n < 20);
      check_val("t2_lat1", n, 4);
      check_val("t2_dac1", dac_o, 16'h1234);
      n = 0;
      do begin step(); n++; end while (!dac_strobe_o && n < 20);
      check_val("t2_lat2", n, 4);
      check_val("t2_dac2", dac_o, 16'h5678);
      repeat (4) step();
      check_val("t3_uf", underflow_o, 1);
      check_val("t3_play", playing_o, 0);
      check_val("t3_dac", dac_o, 16'h5678);
      repeat (6) step();
      check_val("t3_uf_sticky", underflow_o, 1);

      // Fill to full, extra byte is held off.
      pulse_clear();
      check_val("t4_uf_clr", underflow_o, 0);
      rate_div_i = 16'hFFFF;
      for (int i = 0; i < 8; i++) send_byte(8'(i + 8'h40));
      check_val("t4_level", fifo_level_o, 4);
      byte_valid_i = 1'b1; byte_i = 8'h99;
      repeat (3) begin
         step();
         check_val("t4_ready", byte_ready_o, 0);
      end
      byte_valid_i = 1'b0;
      check_val("t4_level_hold", fifo_level_o, 4);

      // Clear discards the FIFO and the half-assembled byte.
      pulse_clear();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'hEE);
      pulse_clear();
      check_val("t5_level", fifo_level_o, 0);
      check_val("t5_dac", dac_o, 0);
      check_val("t5_uf", underflow_o, 0);
      send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h02); send_byte(8'h01);
      rate_div_i = 16'd0;
      n = 0;
      do begin step(); n++; end while (!dac_strobe_o && n < 20);
      check_val("t5_head", dac_o, 16'hABCD);
      repeat (4) step();

      // Back-to-back playback with an ena pause in the middle.
      pulse_clear();
      rate_div_i = 16'hFFFF;
      for (int k = 1; k <= 4; k++) begin
         send_byte(8'(k));
         send_byte(8'h00);
      end
      rate_div_i = 16'd0;
      seen.delete();
      n = 0;
      while (!underflow_o && n < 30) begin
         if (seen.size() == 2 && ena) begin
            ena = 1'b0;
            repeat (3) begin
               step();
               check_val("t6_pause_strobe", dac_strobe_o, 0);
            end
            ena = 1'b1;
         end
         step();
         if (dac_strobe_o) seen.push_back(dac_o);
         n++;
      end
      check_val("t6_count", seen.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < seen.size()) check_val("t6_val", seen[k], k + 1);
      end
      check_val("t6_uf", underflow_o, 1);

      // Randomized traffic against the model.
      pulse_clear();
      rate_div_i = 16'd2;
      for (int c = 0; c < 3000; c++) begin
         byte_valid_i = ($urandom_range(0, 9) < 6);
         byte_i       = 8'($urandom);
         ena          = ($urandom_range(0, 9) != 0);
         clear_i      = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 49) == 0) rate_div_i = 16'($urandom_range(0, 6));
         step();
      end
      byte_valid_i = 1'b0; clear_i = 1'b0; ena = 1'b1;

      // Reset mid-stream.
      send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_val("t1_ready", byte_ready_o, ena);
      check_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_outputs();
      send_byte(8'h55); send_byte(8'h66);
      check_val("t1_level", fifo_level_o, 1);
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
